// File: rtl/dm_dump_pkg.sv
// rtl/dm_dump_pkg.sv - shared debug-unit types: dump FSM encoding and byte width.
package dm_dump_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_READ    = 4'd1,
        ST_CAPTURE = 4'd2,
        ST_SEND_HI = 4'd3,
        ST_WAIT_HI = 4'd4,
        ST_SEND_LO = 4'd5,
        ST_WAIT_LO = 4'd6,
        ST_NEXT    = 4'd7,
        ST_DONE    = 4'd8
    } dm_state_e;

    function automatic logic [BYTE_W-1:0] hi_byte(input logic [2*BYTE_W-1:0] w);
        return w[2*BYTE_W-1:BYTE_W];
    endfunction

    function automatic logic [BYTE_W-1:0] lo_byte(input logic [2*BYTE_W-1:0] w);
        return w[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/dm_dump.sv
// rtl/dm_dump.sv - dumps every data-memory word over the UART, high byte first.
module dm_dump
    import dm_dump_pkg::*;
#(
    parameter int MEM_SIZE    = 9,
    parameter int ADDR_LENGTH = 11,
    parameter int DATA_LENGTH = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    output logic [ADDR_LENGTH-1:0] o_Addr,
    output logic                   o_Rd,
    input  logic [DATA_LENGTH-1:0] i_Data,
    output logic [BYTE_W-1:0]      o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam logic [ADDR_LENGTH-1:0] LAST_ADDR = ADDR_LENGTH'(MEM_SIZE - 1);

    dm_state_e              state_q, state_d;
    logic [ADDR_LENGTH-1:0] cnt_q, cnt_d;
    logic [DATA_LENGTH-1:0] word_q, word_d;
    logic [BYTE_W-1:0]      tx_data_q, tx_data_d;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            word_q    <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            tx_data_q <= tx_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        tx_data_d = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    cnt_d   = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                // Memory drives i_Data only while Rd is high, so the word is
                // registered on the edge that enters CAPTURE.
                word_d  = i_Data;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                tx_data_d = hi_byte(word_q);
                state_d   = ST_SEND_HI;
            end
            ST_SEND_HI: state_d = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (i_tx_done) begin
                    tx_data_d = lo_byte(word_q);
                    state_d   = ST_SEND_LO;
                end
            end
            ST_SEND_LO: state_d = ST_WAIT_LO;
            ST_WAIT_LO: begin
                if (i_tx_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                // Compare before increment so a full-range dump never wraps.
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + ADDR_LENGTH'(1);
                    state_d = ST_READ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_Addr     = cnt_q;
    assign o_Rd       = (state_q == ST_READ);
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = (state_q == ST_SEND_HI) || (state_q == ST_SEND_LO);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_dm_dump.sv
// tb/tb_dm_dump.sv - directed bench for dm_dump with memory and UART transmitter models.
module tb_dm_dump;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1, inj_done;
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;

    logic [10:0] addr0, addr1;
    logic        rd0, rd1, txs0, txs1, busy0, busy1, done0, done1;
    logic [7:0]  txd0, txd1;
    logic [15:0] data0, data1;
    logic        txdone0, txdone1;
    int          txcnt0, txcnt1;

    logic [7:0]  bytes0[$];
    logic [7:0]  bytes1[$];
    logic [10:0] addrs0[$];
    int          rdcnt1;
    int          done_cnt0, done_cnt1;
    int          first_tx0, first_tx1;
    int          start_cyc0, start_cyc1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_dump #(.MEM_SIZE(9), .ADDR_LENGTH(11), .DATA_LENGTH(16)) u_dut0 (
        .i_clock(clk), .i_reset(rst), .i_start(start0),
        .o_Addr(addr0), .o_Rd(rd0), .i_Data(data0),
        .o_tx_data(txd0), .o_tx_start(txs0), .i_tx_done(txdone0),
        .o_busy(busy0), .o_done(done0)
    );

    dm_dump #(.MEM_SIZE(1), .ADDR_LENGTH(11), .DATA_LENGTH(16)) u_dut1 (
        .i_clock(clk), .i_reset(rst), .i_start(start1),
        .o_Addr(addr1), .o_Rd(rd1), .i_Data(data1),
        .o_tx_data(txd1), .o_tx_start(txs1), .i_tx_done(txdone1),
        .o_busy(busy1), .o_done(done1)
    );

    // Data memories: read on the falling edge, zero when not reading.
    always @(negedge clk) begin
        data0 <= rd0 ? (16'hA000 + {5'd0, addr0}) : 16'h0000;
        data1 <= rd1 ? ((addr1 == 11'd0) ? 16'h1234 : 16'hDEAD) : 16'h0000;
    end

    // Transmitters: i_tx_done pulses 5 cycles after each o_tx_start.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            txcnt0 <= 0;
            txcnt1 <= 0;
        end else begin
            txcnt0 <= txs0 ? 5 : (txcnt0 != 0 ? txcnt0 - 1 : 0);
            txcnt1 <= txs1 ? 5 : (txcnt1 != 0 ? txcnt1 - 1 : 0);
        end
    end
    assign txdone0 = (txcnt0 == 1) || inj_done;
    assign txdone1 = (txcnt1 == 1);

    always @(negedge clk) begin
        if (txs0) begin
            if (first_tx0 < 0) first_tx0 = cyc;
            bytes0.push_back(txd0);
        end
        if (txs1) begin
            if (first_tx1 < 0) first_tx1 = cyc;
            bytes1.push_back(txd1);
        end
        if (rd0) addrs0.push_back(addr0);
        if (rd1) rdcnt1++;
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
    end

    task automatic clear_sb();
        bytes0.delete();
        bytes1.delete();
        addrs0.delete();
        rdcnt1    = 0;
        done_cnt0 = 0;
        done_cnt1 = 0;
        first_tx0 = -1;
        first_tx1 = -1;
    endtask

    task automatic pulse_start(input int which);
        @(posedge clk);
        #1;
        if (which == 0) begin start0 = 1'b1; start_cyc0 = cyc; end
        else begin start1 = 1'b1; start_cyc1 = cyc; end
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int which, input string name);
        int n = 0;
        while (((which == 0) ? done_cnt0 : done_cnt1) == 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (((which == 0) ? done_cnt0 : done_cnt1) == 0)
            $display("FAIL %s_timeout: no o_done within %0d cycles, required one", name, n);
        else passed++;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({addr0, rd0, txd0, txs0, busy0, done0} !== 23'd0)
            $display("FAIL reset_outputs: got addr=%0h rd=%b txd=%0h txs=%b busy=%b done=%b, required all 0",
                     addr0, rd0, txd0, txs0, busy0, done0);
        else passed++;
        total++;
        if (busy1 !== 1'b0) $display("FAIL reset_busy1: got %b, required 0", busy1);
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_full_dump();
        logic [7:0] exp_b;
        clear_sb();
        pulse_start(0);
        total++;
        if (busy0 !== 1'b1 || rd0 !== 1'b1)
            $display("FAIL full_busy_rd_after_start: got busy=%b rd=%b, required 1 1", busy0, rd0);
        else passed++;
        wait_done(0, "full");
        total++;
        if (bytes0.size() != 18) $display("FAIL full_byte_count: got %0d, required 18", bytes0.size());
        else passed++;
        for (int i = 0; i < 18 && i < bytes0.size(); i++) begin
            exp_b = (i % 2 == 0) ? 8'hA0 : 8'(i / 2);
            total++;
            if (bytes0[i] !== exp_b) $display("FAIL full_byte[%0d]: got %02h, required %02h", i, bytes0[i], exp_b);
            else passed++;
        end
        total++;
        if (addrs0.size() != 9) $display("FAIL full_rd_count: got %0d, required 9", addrs0.size());
        else passed++;
        for (int i = 0; i < 9 && i < addrs0.size(); i++) begin
            total++;
            if (addrs0[i] !== 11'(i)) $display("FAIL full_addr[%0d]: got %0d, required %0d", i, addrs0[i], i);
            else passed++;
        end
        total++;
        if (done_cnt0 != 1) $display("FAIL full_done_count: got %0d, required 1", done_cnt0);
        else passed++;
        total++;
        if (busy0 !== 1'b0) $display("FAIL full_busy_after: got %b, required 0", busy0);
        else passed++;
        total++;
        if (first_tx0 - start_cyc0 != 3)
            $display("FAIL full_latency: got %0d, required 3", first_tx0 - start_cyc0);
        else passed++;
    endtask

    task automatic test_ignored_inputs();
        logic [7:0] exp_b;
        int n = 0;
        clear_sb();
        @(posedge clk);
        #1;
        inj_done = 1'b1;
        @(posedge clk);
        #1;
        inj_done = 1'b0;
        total++;
        if (busy0 !== 1'b0) $display("FAIL ign_idle_done_busy: got %b, required 0", busy0);
        else passed++;
        pulse_start(0);
        while (bytes0.size() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        // Next cycle the FSM sits in WAIT_HI.
        @(posedge clk);
        #1;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        wait_done(0, "ign");
        total++;
        if (bytes0.size() != 18) $display("FAIL ign_byte_count: got %0d, required 18", bytes0.size());
        else passed++;
        for (int i = 0; i < 18 && i < bytes0.size(); i++) begin
            exp_b = (i % 2 == 0) ? 8'hA0 : 8'(i / 2);
            total++;
            if (bytes0[i] !== exp_b) $display("FAIL ign_byte[%0d]: got %02h, required %02h", i, bytes0[i], exp_b);
            else passed++;
        end
        total++;
        if (addrs0.size() != 9) $display("FAIL ign_rd_count: got %0d, required 9", addrs0.size());
        else passed++;
        for (int i = 0; i < 9 && i < addrs0.size(); i++) begin
            total++;
            if (addrs0[i] !== 11'(i)) $display("FAIL ign_addr[%0d]: got %0d, required %0d", i, addrs0[i], i);
            else passed++;
        end
        total++;
        if (done_cnt0 != 1) $display("FAIL ign_done_count: got %0d, required 1", done_cnt0);
        else passed++;
    endtask

    task automatic test_reset_mid_dump();
        logic [7:0] exp_b;
        int n = 0;
        clear_sb();
        pulse_start(0);
        while (bytes0.size() < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bytes0.size() < 5) $display("FAIL mid_reach_5th_byte: got %0d bytes, required 5", bytes0.size());
        else passed++;
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({addr0, rd0, txd0, txs0, busy0, done0} !== 23'd0)
            $display("FAIL mid_reset_outputs: got addr=%0h rd=%b txd=%0h txs=%b busy=%b done=%b, required all 0",
                     addr0, rd0, txd0, txs0, busy0, done0);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        total++;
        if (done_cnt0 != 0 || busy0 !== 1'b0)
            $display("FAIL mid_no_done: got done_cnt=%0d busy=%b, required 0 0", done_cnt0, busy0);
        else passed++;
        clear_sb();
        pulse_start(0);
        wait_done(0, "mid_restart");
        total++;
        if (bytes0.size() != 18) $display("FAIL mid_restart_count: got %0d, required 18", bytes0.size());
        else passed++;
        for (int i = 0; i < 18 && i < bytes0.size(); i++) begin
            exp_b = (i % 2 == 0) ? 8'hA0 : 8'(i / 2);
            total++;
            if (bytes0[i] !== exp_b) $display("FAIL mid_restart_byte[%0d]: got %02h, required %02h", i, bytes0[i], exp_b);
            else passed++;
        end
        total++;
        if (addrs0.size() == 0 || addrs0[0] !== 11'd0)
            $display("FAIL mid_restart_addr0: got %0d reads, first addr %0d, required address 0",
                     addrs0.size(), (addrs0.size() == 0) ? -1 : int'(addrs0[0]));
        else passed++;
    endtask

    task automatic test_single_word();
        clear_sb();
        pulse_start(1);
        wait_done(1, "single");
        total++;
        if (bytes1.size() != 2) $display("FAIL single_byte_count: got %0d, required 2", bytes1.size());
        else passed++;
        total++;
        if (bytes1.size() < 1 || bytes1[0] !== 8'h12)
            $display("FAIL single_hi: got %02h, required 12", (bytes1.size() < 1) ? 8'hxx : bytes1[0]);
        else passed++;
        total++;
        if (bytes1.size() < 2 || bytes1[1] !== 8'h34)
            $display("FAIL single_lo: got %02h, required 34", (bytes1.size() < 2) ? 8'hxx : bytes1[1]);
        else passed++;
        total++;
        if (done_cnt1 != 1 || rdcnt1 != 1)
            $display("FAIL single_done_rd: got done=%0d rd=%0d, required 1 1", done_cnt1, rdcnt1);
        else passed++;
        total++;
        if (first_tx1 - start_cyc1 != 3)
            $display("FAIL single_latency: got %0d, required 3", first_tx1 - start_cyc1);
        else passed++;
        total++;
        if (busy1 !== 1'b0) $display("FAIL single_busy_after: got %b, required 0", busy1);
        else passed++;
    endtask

    initial begin
        rst      = 1'b1;
        start0   = 1'b0;
        start1   = 1'b0;
        inj_done = 1'b0;
        clear_sb();
        test_reset();
        test_full_dump();
        test_ignored_inputs();
        test_reset_mid_dump();
        test_single_word();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dm_dump.md
DM_DUMP -- requirements
Module: dm_dump

Interface
REQ-001 Parameter MEM_SIZE, default 9: number of data-memory words dumped per run; SHALL satisfy 1 <= MEM_SIZE <= 2^ADDR_LENGTH.
REQ-002 Parameter ADDR_LENGTH, default 11: data-memory address width.
REQ-003 Parameter DATA_LENGTH, default 16: data-memory word width; SHALL be fixed at 16 (two bytes per word).
REQ-004 i_clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_start  input  1  one-cycle request to dump the whole data memory.
REQ-007 o_Addr  output  ADDR_LENGTH  data-memory address.
REQ-008 o_Rd  output  1  data-memory read enable.
REQ-009 i_Data  input  DATA_LENGTH  data-memory read data; valid on the rising edge after o_Rd is asserted, because the memory samples on the falling edge.
REQ-010 o_tx_data  output  8  byte presented to the UART transmitter.
REQ-011 o_tx_start  output  1  one-cycle pulse that launches transmission of o_tx_data.
REQ-012 i_tx_done  input  1  one-cycle pulse from the transmitter when a byte has been sent.
REQ-013 o_busy  output  1  high from the cycle after an accepted i_start until DONE is left.
REQ-014 o_done  output  1  one-cycle pulse when the last byte has been sent.

Function
REQ-015 FSM states SHALL be IDLE, READ, CAPTURE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, NEXT and DONE.
REQ-016 IDLE: when i_start=1, SHALL clear the address counter and go to READ; otherwise SHALL stay in IDLE.
REQ-017 READ: o_Rd=1 and o_Addr=counter for exactly one cycle, then go to CAPTURE.
REQ-018 CAPTURE: SHALL latch i_Data into a 16-bit word register with o_Rd=0, then go to SEND_HI.
REQ-019 SEND_HI: o_tx_data=word[15:8] and o_tx_start=1 for one cycle, then go to WAIT_HI.
REQ-020 WAIT_HI: SHALL hold o_tx_data and go to SEND_LO on i_tx_done=1.
REQ-021 SEND_LO and WAIT_LO: same as SEND_HI and WAIT_HI using word[7:0]; on i_tx_done, go to NEXT.
REQ-022 NEXT: if counter == MEM_SIZE-1, go to DONE; else increment the counter and go to READ.
REQ-023 DONE: o_done=1 for one cycle, then go to IDLE.
REQ-024 Byte order SHALL be high byte first; words SHALL be sent in ascending address order from 0.
REQ-025 Latency: o_tx_start for the first byte SHALL occur 3 cycles after the i_start cycle.
REQ-026 o_Rd SHALL only be high in READ; the block SHALL never write to memory.
REQ-027 i_start SHALL be ignored outside IDLE; i_tx_done SHALL be ignored outside WAIT_HI and WAIT_LO.
REQ-028 If i_tx_done arrives in the same cycle the FSM enters a WAIT state, it SHALL NOT count; only pulses seen while in the WAIT state advance it.
REQ-029 The counter SHALL be ADDR_LENGTH bits wide; with MEM_SIZE = 2^ADDR_LENGTH it SHALL terminate via the REQ-022 compare and never wrap.
REQ-030 o_busy SHALL be low in IDLE and high in every other state.

Reset
REQ-031 Asserting i_reset SHALL immediately force IDLE, counter=0, word=0, o_Addr=0, o_Rd=0, o_tx_data=0, o_tx_start=0, o_busy=0 and o_done=0.
REQ-032 Reset mid-dump SHALL abort without a completing o_done; the next i_start SHALL restart at address 0.

Structure
REQ-033 The FSM state encoding and the byte-width constant (8) SHALL live in the shared package used by the debug-unit blocks.
REQ-034 No sub-module is required; the block SHALL connect directly to the data-memory port and the existing UART transmitter.

Verification
REQ-035 Bench SHALL use a behavioural data memory (falling-edge read, zero when Rd=0) and a transmitter model that pulses i_tx_done 5 cycles after each o_tx_start.
REQ-036 Full dump: MEM_SIZE=9, word k = 16'hA000+k, pulse i_start -> 18 bytes A0,00,A0,01,...,A0,08 in order, then one o_done pulse, o_busy low afterwards.
REQ-037 Read timing: o_Rd is high for exactly one cycle per word (9 total), with o_Addr = 0..8, and the captured word equals memory content.
REQ-038 Ignored inputs: i_start pulsed during WAIT_HI and i_tx_done pulsed in IDLE -> byte stream and address sequence unchanged.
REQ-039 Reset mid-dump: assert i_reset after the 5th byte -> all outputs 0 immediately, no o_done; a new i_start -> stream restarts with A0,00.
REQ-040 MEM_SIZE=1, word 0 = 16'h1234 -> bytes 12,34, then o_done; first o_tx_start occurs 3 cycles after i_start.
